// File: rtl/wall_spawn_ctrl.sv
// wall_spawn_ctrl: samples candidate wall positions, rejects ones that land on
// the snake head, the apple or an existing wall, and commits accepted ones into
// a fill-in-order wall table. Also flags snake-head-vs-wall collisions.
module wall_spawn_ctrl #(
  parameter  int NUM_WALLS = 8,
  parameter  int MAX_TRIES = 15,
  localparam int IW        = $clog2(NUM_WALLS),
  localparam int CW        = IW + 1
) (
  input  logic          clk,
  input  logic          btnrst_n,
  input  logic          spawn_req,
  input  logic          clear,
  input  logic [10:0]   cand_x,
  input  logic [10:0]   cand_y,
  input  logic [10:0]   snakehead_x,
  input  logic [10:0]   snakehead_y,
  input  logic [10:0]   apple_x,
  input  logic [10:0]   apple_y,
  input  logic [IW-1:0] rd_idx,
  output logic [10:0]   rd_x,
  output logic [10:0]   rd_y,
  output logic          rd_valid,
  output logic [CW-1:0] wall_count,
  output logic          busy,
  output logic          spawn_done,
  output logic          spawn_fail,
  output logic          wall_hit
);

  typedef enum logic [1:0] {IDLE, SAMPLE, CHECK} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    tries_q;
  logic [10:0]   cand_x_q, cand_y_q;
  logic          done_q, fail_q, hit_q;
  logic [10:0]   slot_x_q [NUM_WALLS];
  logic [10:0]   slot_y_q [NUM_WALLS];

  logic          slot_conf, head_hit_d, conflict, commit, retry_ok;
  logic [8:0]    tries_nxt;

  // Compare the candidate and the live head against every occupied slot.
  always_comb begin
    slot_conf  = 1'b0;
    head_hit_d = 1'b0;
    for (int i = 0; i < NUM_WALLS; i++) begin
      if (CW'(i) < cnt_q) begin
        if (slot_x_q[i] == cand_x_q && slot_y_q[i] == cand_y_q)       slot_conf  = 1'b1;
        if (slot_x_q[i] == snakehead_x && slot_y_q[i] == snakehead_y) head_hit_d = 1'b1;
      end
    end
  end

  assign conflict  = slot_conf
                   | (cand_x_q == snakehead_x && cand_y_q == snakehead_y)
                   | (cand_x_q == apple_x && cand_y_q == apple_y);
  // clear beats a simultaneous commit, so it also blocks the table write.
  assign commit    = (state_q == CHECK) && !conflict && !clear;
  assign tries_nxt = {1'b0, tries_q} + 9'd1;
  assign retry_ok  = tries_nxt < 9'(MAX_TRIES);

  // Control FSM with registered pulses and collision flag.
  always_ff @(posedge clk) begin
    if (!btnrst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tries_q  <= '0;
      cand_x_q <= '0;
      cand_y_q <= '0;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      fail_q <= 1'b0;
      hit_q  <= head_hit_d;
      if (clear) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: if (spawn_req) begin
            if (cnt_q < CW'(NUM_WALLS)) begin
              tries_q <= '0;
              state_q <= SAMPLE;
            end else begin
              fail_q  <= 1'b1;
            end
          end
          SAMPLE: begin
            cand_x_q <= cand_x;
            cand_y_q <= cand_y;
            state_q  <= CHECK;
          end
          CHECK: begin
            if (!conflict) begin
              cnt_q   <= cnt_q + 1'b1;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else if (retry_ok) begin
              tries_q <= tries_nxt[7:0];
              state_q <= SAMPLE;
            end else begin
              fail_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Wall table storage; unoccupied slots are don't-care so no reset is needed.
  always_ff @(posedge clk) begin
    if (btnrst_n && commit) begin
      slot_x_q[cnt_q[IW-1:0]] <= cand_x_q;
      slot_y_q[cnt_q[IW-1:0]] <= cand_y_q;
    end
  end

  assign rd_x       = slot_x_q[rd_idx];
  assign rd_y       = slot_y_q[rd_idx];
  assign rd_valid   = {1'b0, rd_idx} < cnt_q;
  assign wall_count = cnt_q;
  assign busy       = state_q != IDLE;
  assign spawn_done = done_q;
  assign spawn_fail = fail_q;
  assign wall_hit   = hit_q;

endmodule

// File: doc/wall_spawn_ctrl.md
# wall_spawn_ctrl

Sequences wall placement for the snake playfield. On each spawn request it samples the free-running wall position generator and rejects any candidate that coincides with the snake head, the apple or an existing wall. Accepted candidates are committed into a small wall table. It also drives a registered snake-head-vs-wall collision flag to the game FSM. It sits between the wall position generator and the game-state / VGA draw logic.

## Interface
- NUM_WALLS, 8, wall table depth (power of two, 2..16)
- MAX_TRIES, 15, conflicting candidates tolerated per request before giving up (1..255)
- clk  in  1  system clock; all logic on rising edge
- btnrst_n  in  1  synchronous, active-low reset
- spawn_req  in  1  one-cycle request to place a wall
- clear  in  1  one-cycle request to empty the wall table
- cand_x, cand_y  in  11 each  candidate position from the wall generator; changes every cycle
- snakehead_x, snakehead_y  in  11 each  current snake head position
- apple_x, apple_y  in  11 each  current apple position
- rd_idx  in  log2(NUM_WALLS)  table read index for the draw logic
- rd_x, rd_y  out  11 each  position stored at rd_idx (combinational read)
- rd_valid  out  1  slot rd_idx is occupied (rd_idx < wall_count)
- wall_count  out  log2(NUM_WALLS)+1  occupied slots
- busy  out  1  high whenever state != IDLE
- spawn_done  out  1  one-cycle pulse: wall committed
- spawn_fail  out  1  one-cycle pulse: request rejected (table full or retries exhausted)
- wall_hit  out  1  registered: snake head equals a valid wall position

## Operation
- States: IDLE, SAMPLE, CHECK.
- IDLE:
  - spawn_req with wall_count < NUM_WALLS: clear the try counter and go to SAMPLE.
  - spawn_req with the table full: pulse spawn_fail on the next cycle and stay in IDLE; the table is unchanged.
- SAMPLE: register cand_x/cand_y into cand_r, then go to CHECK.
- CHECK: conflict = cand_r equals (snakehead) OR equals (apple) OR equals any slot i < wall_count. Equality means both x and y are equal, 11-bit exact.
  - No conflict: write cand_r into slot[wall_count], increment wall_count, pulse spawn_done, go to IDLE.
  - Conflict and tries+1 < MAX_TRIES: increment tries, go to SAMPLE.
  - Conflict and tries+1 == MAX_TRIES: pulse spawn_fail, go to IDLE. No write.
- spawn_req while busy is ignored and not queued.
- Slots fill in order 0,1,2,…; there is no per-slot deletion. Slots at or above wall_count are don't-care; clear does not zero them.
- clear, in any state: wall_count becomes 0, state becomes IDLE, any in-flight request is aborted with no done or fail pulse. clear beats a simultaneous spawn_req and a simultaneous commit.
- wall_hit is evaluated every cycle, independent of the FSM, against slots < wall_count using the head value on that edge.

## Timing
- Reset (btnrst_n = 0 at an edge): state IDLE, wall_count 0, tries 0, cand_r 0, busy 0, spawn_done 0, spawn_fail 0, wall_hit 0. Reset overrides clear and spawn_req. Reset mid-spawn aborts the spawn with no pulse.
- Request accepted at edge E0:
  - busy is high from E0 to the final edge.
  - cand_r holds the cand value present at E1.
  - If clean, the commit happens at E2: spawn_done and the new wall_count are visible after E2, and busy drops after E2.
  - Each conflict adds 2 cycles. Worst-case fail is visible after edge E(2·MAX_TRIES).
- Full-table reject: spawn_fail is visible after E0 for exactly one cycle; busy stays 0.
- A table write at edge E is visible on rd_x/rd_y/rd_valid and in wall_hit evaluation from E+1 onward.
- wall_hit latency is 1 cycle from snakehead change.
- spawn_done and spawn_fail are never high together. Each is high for exactly one cycle.

## Test plan
- Reset: hold btnrst_n = 0 for 2 cycles with spawn_req = 1 -> all outputs 0 and wall_count 0 after release.
- Clean spawn: cand = (16,144) at E1, head (400,400), apple (600,600) -> spawn_done after E2; slot0 = (16,144); wall_count 1; rd_valid at rd_idx 0 = 1.
- Retry then success: cand = head at E1, (80,176) at E3 -> one retry; commit (80,176) after E4; spawn_done visible after E4.
- Retry exhaustion: MAX_TRIES = 3, cand always equal to apple -> spawn_fail after E6, wall_count unchanged, busy 0.
- Full table: 8 successful spawns, then spawn_req -> spawn_fail the next cycle, wall_count stays 8. clear -> wall_count 0 next cycle, rd_valid 0.
- Collision flag: wall stored at (48,208); drive head to (48,208) -> wall_hit = 1 one cycle later. Head to (48,240) -> wall_hit = 0 one cycle later. clear mid-spawn (in CHECK) -> no pulse, busy 0 next cycle.
